// File: rtl/dcache_victim_ctrl_pkg.sv
// rtl/dcache_victim_ctrl_pkg.sv - widths, line/tag types and FSM states for the victim-cache miss controller
package dcache_vc_pkg;
    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DCACHE_TAG_BITS   = 23;
    localparam int VICTIM_NO_OF_SETS = 4;

    typedef logic [DCACHE_TAG_BITS-1:0]   tag_t;
    typedef logic [DCACHE_LINE_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        VC_WR,
        WB,
        MEM_RD,
        RESP
    } vc_state_e;
endpackage

// File: rtl/dcache_victim_ctrl_if.sv
// rtl/dcache_victim_ctrl_if.sv - line-granular memory port (req/ack handshake) between the miss controller and memory
interface dcache_victim_ctrl_if;
    import dcache_vc_pkg::*;

    logic  req;
    logic  we;
    tag_t  addr;
    line_t wdata;
    logic  ack;
    line_t rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dcache_victim_ctrl.sv
// rtl/dcache_victim_ctrl.sv - L1 miss controller: victim probe/fill, writeback, memory refill
// Victim cache path enabled by DCACHE_VICTIM_EN; without it every miss reads memory.
module dcache_victim_ctrl
    import dcache_vc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  miss_req_i,
    input  tag_t  miss_addr_i,
    input  logic  evict_valid_i,
    input  logic  evict_dirty_i,
    input  tag_t  evict_addr_i,
    input  line_t evict_data_i,
    output logic  fill_valid_o,
    output line_t fill_data_o,
    output tag_t  vc_tag_o,
    output line_t vc_data_o,
    output logic  vc_wr_o,
    input  logic  vc_hit_i,
    input  line_t vc_rdata_i,
    dcache_victim_ctrl_if.master mem
);
    vc_state_e state_q;
    tag_t      miss_addr_q;
    line_t     line_q;
    logic      fill_valid_q;
    logic      mem_req_q;
    logic      mem_we_q;
    tag_t      mem_addr_q;
    line_t     mem_wdata_q;
    logic      wb_hit;

`ifdef DCACHE_VICTIM_EN
    logic  evict_valid_q;
    logic  evict_dirty_q;
    tag_t  evict_addr_q;
    line_t evict_data_q;
    logic  hit_q;
    logic  vc_wr_q;
    tag_t  vc_tag_q;
    line_t vc_data_q;
    logic  probe_hit;

    // Victim tags reset to 0, so a zero-address probe would match empty slots.
    assign probe_hit = vc_hit_i && (miss_addr_q != '0);
    assign wb_hit    = hit_q;
    assign vc_tag_o  = vc_tag_q;
    assign vc_data_o = vc_data_q;
    assign vc_wr_o   = vc_wr_q;
`else
    logic unused_vc;
    assign unused_vc = ^{vc_hit_i, vc_rdata_i};
    assign wb_hit    = 1'b0;
    assign vc_tag_o  = '0;
    assign vc_data_o = '0;
    assign vc_wr_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            line_q       <= '0;
            fill_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef DCACHE_VICTIM_EN
            evict_valid_q <= 1'b0;
            evict_dirty_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            hit_q         <= 1'b0;
            vc_wr_q       <= 1'b0;
            vc_tag_q      <= '0;
            vc_data_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_req_i) begin
                        miss_addr_q <= miss_addr_i;
`ifdef DCACHE_VICTIM_EN
                        evict_valid_q <= evict_valid_i;
                        evict_dirty_q <= evict_dirty_i;
                        evict_addr_q  <= evict_addr_i;
                        evict_data_q  <= evict_data_i;
                        vc_tag_q      <= miss_addr_i;
                        state_q       <= PROBE;
`else
                        mem_req_q <= 1'b1;
                        if (evict_valid_i && evict_dirty_i) begin
                            state_q     <= WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= evict_addr_i;
                            mem_wdata_q <= evict_data_i;
                        end else begin
                            state_q    <= MEM_RD;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= miss_addr_i;
                        end
`endif
                    end
                end
`ifdef DCACHE_VICTIM_EN
                PROBE: begin
                    hit_q  <= probe_hit;
                    line_q <= vc_rdata_i;
                    if (evict_valid_q) begin
                        state_q   <= VC_WR;
                        vc_wr_q   <= (evict_addr_q != '0);
                        vc_tag_q  <= evict_addr_q;
                        vc_data_q <= evict_data_q;
                    end else if (probe_hit) begin
                        state_q      <= RESP;
                        fill_valid_q <= 1'b1;
                    end else begin
                        state_q    <= MEM_RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= miss_addr_q;
                    end
                end
                VC_WR: begin
                    vc_wr_q   <= 1'b0;
                    vc_tag_q  <= miss_addr_q;
                    vc_data_q <= '0;
                    if (evict_dirty_q) begin
                        state_q     <= WB;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= evict_addr_q;
                        mem_wdata_q <= evict_data_q;
                    end else if (hit_q) begin
                        state_q      <= RESP;
                        fill_valid_q <= 1'b1;
                    end else begin
                        state_q    <= MEM_RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= miss_addr_q;
                    end
                end
`endif
                WB: begin
                    if (mem.ack) begin
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        if (wb_hit) begin
                            state_q      <= RESP;
                            mem_req_q    <= 1'b0;
                            fill_valid_q <= 1'b1;
                        end else begin
                            // Read request follows the writeback without dropping req.
                            state_q    <= MEM_RD;
                            mem_addr_q <= miss_addr_q;
                        end
                    end
                end
                MEM_RD: begin
                    if (mem.ack) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        line_q       <= mem.rdata;
                        fill_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    fill_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fill_valid_o = fill_valid_q;
    assign fill_data_o  = line_q;
    assign mem.req      = mem_req_q;
    assign mem.we       = mem_we_q;
    assign mem.addr     = mem_addr_q;
    assign mem.wdata    = mem_wdata_q;
endmodule

// File: doc/dcache_victim_ctrl.md
# dcache_victim_ctrl

Miss-side controller in the data cache that acts as the initiator for the 4-entry victim cache. On an L1 miss it probes the victim cache, pushes the displaced L1 line into it, writes dirty displaced lines back to memory, and fetches from memory only on a victim miss. It sits between the L1 miss logic, the victim cache, and the memory port, and returns one refill line per miss.

## Interface
- DCACHE_LINE_WIDTH, 128, line width in bits
- DCACHE_TAG_BITS, 23, line address width; used as the victim cache tag
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- miss_req_i  in  1  miss request; held high until fill_valid_o
- miss_addr_i  in  TAG  line address of the missing line
- evict_valid_i  in  1  displaced L1 line is valid
- evict_dirty_i  in  1  displaced line is dirty
- evict_addr_i  in  TAG  displaced line address
- evict_data_i  in  LINE  displaced line data
- fill_valid_o  out  1  one-cycle pulse; refill data valid, request complete
- fill_data_o  out  LINE  refill line
- vc_tag_o  out  TAG  probe tag, or write tag when vc_wr_o=1
- vc_data_o  out  LINE  victim write data
- vc_wr_o  out  1  victim write strobe (one cycle)
- vc_hit_i  in  1  victim hit for vc_tag_o (combinational)
- vc_rdata_i  in  LINE  victim hit data
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  1 = writeback, 0 = line read
- mem_addr_o  out  TAG  line address
- mem_wdata_o  out  LINE  writeback data
- mem_ack_i  in  1  transfer done when mem_req_o & mem_ack_i
- mem_rdata_i  in  LINE  read data, valid with mem_ack_i on reads

## Operation
- States: IDLE, PROBE, VC_WR, WB, MEM_RD, RESP.
- IDLE: when miss_req_i=1, latch miss_addr, evict_valid, evict_dirty, evict_addr and evict_data. Go to PROBE. Latched values are used for the whole transaction. Input changes after latching are ignored.
- PROBE: vc_tag_o = latched miss_addr. Sample vc_hit_i into hit_q and vc_rdata_i into the line buffer. Go to VC_WR.
- Line address 0 is never treated as a hit, because victim tags reset to 0. hit_q is forced to 0 when miss_addr == 0.
- VC_WR: entered only if evict_valid. Drives vc_wr_o=1, vc_tag_o=evict_addr, vc_data_o=evict_data for one cycle. If evict_valid=0, the state is skipped. A displaced line with address 0 is not written.
- WB: entered only if evict_valid & evict_dirty. mem_we_o=1, mem_addr_o=evict_addr, mem_wdata_o=evict_data. Waits for mem_ack_i.
- After VC_WR/WB: if hit_q=1 go to RESP. Otherwise go to MEM_RD.
- MEM_RD: mem_we_o=0, mem_addr_o=miss_addr. On mem_ack_i, capture mem_rdata_i into the line buffer and go to RESP.
- RESP: fill_valid_o=1 for one cycle, fill_data_o = line buffer. Go to IDLE.
- A new miss is accepted no earlier than the cycle after RESP.
- The victim cache has no invalidate port. A hit line remains resident there as a duplicate. Every dirty eviction is written back to memory, so victim entries are always clean copies.

## Timing
- Reset values: all outputs 0, state IDLE, line buffer 0, hit_q 0.
- Reset asserted mid-transaction: immediate return to IDLE; mem_req_o and vc_wr_o drop asynchronously. The abandoned memory transfer is not reissued.
- Cycle 0 = first cycle IDLE sees miss_req_i.
- Victim hit, clean or invalid evict: PROBE at cycle 1, VC_WR at 2, fill_valid_o at cycle 3 (2 if evict invalid).
- Dirty evict: WB adds 1 + N cycles, where N is the number of wait cycles before mem_ack_i.
- Victim miss: MEM_RD adds 1 + N cycles.
- Memory ack is accepted in the same cycle as the request. mem_addr_o, mem_we_o and mem_wdata_o are stable while mem_req_o=1.
- mem_ack_i without mem_req_o is ignored.
- vc_tag_o holds miss_addr in every state except VC_WR.

## Configuration
- DCACHE_VICTIM_EN defined: behaviour as above.
- DCACHE_VICTIM_EN undefined:
  - PROBE and VC_WR are removed; vc_wr_o, vc_tag_o and vc_data_o are tied 0.
  - Flow is IDLE → WB (dirty only) → MEM_RD → RESP; every miss reads memory.

## Structure
- Package dcache_vc_pkg holds DCACHE_LINE_WIDTH, DCACHE_TAG_BITS, VICTIM_NO_OF_SETS and the vc_state_e enum.
- No sub-module: the FSM and line buffer are in one module. victim_cache is instantiated alongside this block by the dcache top.

## Test plan
- Miss 0x0001A, victim pre-loaded with 0x0001A/line A, evict 0x00033 clean → vc_wr_o at cycle 2 with tag 0x00033, fill_valid_o at cycle 3 with A, mem_req_o never asserted.
- Miss 0x00050, victim miss, evict invalid, memory acks after 3 waits with B → one read to 0x00050, fill_data_o=B, no vc_wr_o.
- Miss with dirty evict 0x00077/C, victim miss → victim write of C, then mem write 0x00077/C, then mem read, then fill. Order must be exactly that.
- Miss at address 0 after reset (victim tags all 0) → no hit; memory read issued.
- Reset pulled low during WB wait → all outputs 0 next edge. A following miss completes normally.
- Build without DCACHE_VICTIM_EN: same stimulus as the first scenario → vc_wr_o stays 0 and a memory read to 0x0001A is issued.
